// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and helpers for the synchronous FIFO slice.
//   - clog2      : ceiling log2, usable in constant expressions
//   - cnt_w      : width of the occupancy counter (must be able to hold DEPTH)
//   - is_pow2    : power-of-two test for the depth parameter
//   - params_ok  : legality of the full parameter set, checked at elaboration
//   No ports (package).
// ----------------------------------------------------------------------------
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // The counter needs one bit more than the pointers so that "full"
    // (count == DEPTH) is distinguishable from "empty" (count == 0).
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && is_pow2(depth) && (depth >= 4) &&
               (af_level >= 1) && (af_level <= depth - 1) &&
               (ae_level >= 1) && (ae_level <= depth - 1);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_sync_param_if.sv
// ----------------------------------------------------------------------------
// fifo_sync_param_if
//   Bundles the producer/consumer side of the FIFO.
//   master : the user side (drives buf_in, wr_en, rd_en; observes status)
//   slave  : the FIFO itself
//   Signals:
//     buf_in        write data                 wr_en      write request
//     rd_en         read request / pop         buf_out    read data
//     buf_empty     no entries stored          buf_full   DEPTH entries stored
//     almost_empty  count <= AE_LEVEL          almost_full count >= AF_LEVEL
//     fifo_counter  entries stored             overflow / underflow error pulses
//   Handshake: a write is taken on a rising edge when wr_en is high and the
//   FIFO is not full, or is full but a read is taken on the same edge; a read
//   is taken when rd_en is high and the FIFO is not empty. Rejected requests
//   leave state untouched and raise overflow/underflow for the next cycle.
// ----------------------------------------------------------------------------
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] buf_in;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] buf_out;
    logic              buf_empty;
    logic              buf_full;
    logic              almost_empty;
    logic              almost_full;
    logic [CNT_W-1:0]  fifo_counter;
    logic              overflow;
    logic              underflow;

    modport master (
        output buf_in, wr_en, rd_en,
        input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
               fifo_counter, overflow, underflow
    );

    modport slave (
        input  buf_in, wr_en, rd_en,
        output buf_out, buf_empty, buf_full, almost_empty, almost_full,
               fifo_counter, overflow, underflow
    );

endinterface : fifo_sync_param_if

// File: rtl/fifo_mem_dp.sv
// ----------------------------------------------------------------------------
// fifo_mem_dp
//   Simple dual-port storage: one synchronous write port, one asynchronous
//   read port, DATA_W x DEPTH. Contents are deliberately not reset.
//   Ports:
//     clk      in   write clock
//     we_i     in   write enable
//     waddr_i  in   write address
//     wdata_i  in   write data
//     raddr_i  in   read address
//     rdata_o  out  read data (combinational from raddr_i)
// ----------------------------------------------------------------------------
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem_dp

// File: rtl/fifo_sync_param.sv
// ----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO with same-cycle read+write, programmable
//   almost-full/almost-empty thresholds, overflow/underflow pulses and an
//   optional first-word-fall-through read mode.
//   Ports:
//     clk   in      rising-edge clock
//     rst   in      asynchronous, active-high reset
//     bus   slave   fifo_sync_param_if (data, requests, flags, count, errors)
//   All flags are registered from the next-state count, so they change on the
//   same edge as fifo_counter.
// ----------------------------------------------------------------------------
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = 56,
    parameter int AE_LEVEL = 8,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    fifo_sync_param_if.slave  bus
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_sync_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              aempty_q, aempty_d;
    logic              afull_q, afull_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_data;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_acc = bus.rd_en & ~empty_q;
    assign wr_acc = bus.wr_en & (~full_q | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        empty_d     = (count_d == '0);
        full_d      = (count_d == CNT_W'(DEPTH));
        aempty_d    = (count_d <= CNT_W'(AE_LEVEL));
        afull_d     = (count_d >= CNT_W'(AF_LEVEL));
        overflow_d  = bus.wr_en & ~wr_acc;
        underflow_d = bus.rd_en & empty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            aempty_q    <= aempty_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.buf_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; forced to zero while empty so the
        // output is stable and matches the reset value.
        assign bus.buf_out = empty_q ? '0 : rd_data;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        // When full with a simultaneous write, wr_ptr == rd_ptr; the async
        // read still returns the pre-edge word, so the popped data is correct.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign bus.buf_out = dout_q;
    end

    assign bus.buf_empty    = empty_q;
    assign bus.buf_full     = full_q;
    assign bus.almost_empty = aempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.fifo_counter = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;
    localparam int STAT_W = DATA_W + CNT_W + 6;

    // Status vector layout: {buf_out, count, empty, full, aempty, afull, ovf, udf}
    localparam logic [STAT_W-1:0] RESET_STAT = {8'h00, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
    fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

    fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(56), .AE_LEVEL(8), .FWFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(56), .AE_LEVEL(8), .FWFT(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_d;
    logic [STAT_W-1:0] stat;

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.buf_in = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.buf_in = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        #12;
        stat = {bus0.buf_out, bus0.fifo_counter, bus0.buf_empty, bus0.buf_full,
                bus0.almost_empty, bus0.almost_full, bus0.overflow, bus0.underflow};
        n_cmp++;
        if (stat !== RESET_STAT) begin
            n_bad++; $display("FAIL reset_dut0: got %h expected %h", stat, RESET_STAT);
        end
        stat = {bus1.buf_out, bus1.fifo_counter, bus1.buf_empty, bus1.buf_full,
                bus1.almost_empty, bus1.almost_full, bus1.overflow, bus1.underflow};
        n_cmp++;
        if (stat !== RESET_STAT) begin
            n_bad++; $display("FAIL reset_dut1: got %h expected %h", stat, RESET_STAT);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 64; i++) begin
            bus0.wr_en = 1'b1;
            bus0.buf_in = DATA_W'(i);
            cyc();
            exp_q.push_back(DATA_W'(i));
            n_cmp++;
            if (bus0.fifo_counter !== CNT_W'(i)) begin
                n_bad++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus0.fifo_counter, i);
            end
            n_cmp++;
            if (bus0.almost_full !== (i >= 56)) begin
                n_bad++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, bus0.almost_full, (i >= 56));
            end
            n_cmp++;
            if (bus0.buf_full !== (i == 64)) begin
                n_bad++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus0.buf_full, (i == 64));
            end
            n_cmp++;
            if (bus0.buf_empty !== 1'b0) begin
                n_bad++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, bus0.buf_empty);
            end
        end
        bus0.buf_in = 8'hEE;          // 65th write, must be rejected
        cyc();
        bus0.wr_en = 1'b0;
        n_cmp++;
        if (bus0.overflow !== 1'b1) begin
            n_bad++; $display("FAIL overflow_pulse: got %b expected 1", bus0.overflow);
        end
        n_cmp++;
        if (bus0.fifo_counter !== 7'd64 || bus0.buf_full !== 1'b1) begin
            n_bad++; $display("FAIL overflow_count: got %0d/%b expected 64/1", bus0.fifo_counter, bus0.buf_full);
        end
        cyc();
        n_cmp++;
        if (bus0.overflow !== 1'b0) begin
            n_bad++; $display("FAIL overflow_clear: got %b expected 0", bus0.overflow);
        end
    endtask

    task automatic test_drain();
        n_cmp++;
        if (bus0.buf_out !== 8'h00) begin
            n_bad++; $display("FAIL drain_pre_out: got %h expected 00", bus0.buf_out);
        end
        for (int i = 1; i <= 64; i++) begin
            bus0.rd_en = 1'b1;
            cyc();
            exp_d = exp_q.pop_front();
            n_cmp++;
            if (bus0.buf_out !== exp_d || bus0.buf_out !== DATA_W'(i)) begin
                n_bad++; $display("FAIL drain_data[%0d]: got %h expected %h", i, bus0.buf_out, exp_d);
            end
            n_cmp++;
            if (bus0.fifo_counter !== CNT_W'(64 - i)) begin
                n_bad++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, bus0.fifo_counter, 64 - i);
            end
            n_cmp++;
            if (bus0.buf_empty !== (i == 64)) begin
                n_bad++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, bus0.buf_empty, (i == 64));
            end
            n_cmp++;
            if (bus0.almost_empty !== ((64 - i) <= 8)) begin
                n_bad++; $display("FAIL drain_aempty[%0d]: got %b expected %b", i, bus0.almost_empty, ((64 - i) <= 8));
            end
        end
        cyc();                        // extra read of an empty FIFO
        bus0.rd_en = 1'b0;
        n_cmp++;
        if (bus0.underflow !== 1'b1) begin
            n_bad++; $display("FAIL underflow_pulse: got %b expected 1", bus0.underflow);
        end
        n_cmp++;
        if (bus0.buf_out !== 8'h40 || bus0.fifo_counter !== 7'd0) begin
            n_bad++; $display("FAIL underflow_hold: got %h/%0d expected 40/0", bus0.buf_out, bus0.fifo_counter);
        end
        cyc();
        n_cmp++;
        if (bus0.underflow !== 1'b0) begin
            n_bad++; $display("FAIL underflow_clear: got %b expected 0", bus0.underflow);
        end
    endtask

    task automatic test_full_rw();
        // Shift both pointers off zero so the fill and drain wrap 63 -> 0.
        for (int k = 0; k < 5; k++) begin
            bus0.wr_en = 1'b1; bus0.buf_in = DATA_W'(8'h50 + k);
            cyc();
            bus0.wr_en = 1'b0; bus0.rd_en = 1'b1;
            cyc();
            bus0.rd_en = 1'b0;
            n_cmp++;
            if (bus0.buf_out !== DATA_W'(8'h50 + k)) begin
                n_bad++; $display("FAIL shift_data[%0d]: got %h expected %h", k, bus0.buf_out, 8'h50 + k);
            end
        end
        for (int k = 0; k < 64; k++) begin
            bus0.wr_en = 1'b1; bus0.buf_in = DATA_W'(8'h80 + k);
            cyc();
            exp_q.push_back(DATA_W'(8'h80 + k));
        end
        bus0.wr_en = 1'b0;
        n_cmp++;
        if (bus0.fifo_counter !== 7'd64 || bus0.buf_full !== 1'b1) begin
            n_bad++; $display("FAIL refill: got %0d/%b expected 64/1", bus0.fifo_counter, bus0.buf_full);
        end
        for (int k = 0; k < 10; k++) begin
            bus0.wr_en = 1'b1; bus0.rd_en = 1'b1; bus0.buf_in = DATA_W'(8'hC0 + k);
            cyc();
            exp_q.push_back(DATA_W'(8'hC0 + k));
            exp_d = exp_q.pop_front();
            n_cmp++;
            if (bus0.buf_out !== exp_d) begin
                n_bad++; $display("FAIL rw_data[%0d]: got %h expected %h", k, bus0.buf_out, exp_d);
            end
            n_cmp++;
            if (bus0.fifo_counter !== 7'd64 || bus0.buf_full !== 1'b1 || bus0.overflow !== 1'b0) begin
                n_bad++; $display("FAIL rw_flags[%0d]: got %0d/%b/%b expected 64/1/0",
                                  k, bus0.fifo_counter, bus0.buf_full, bus0.overflow);
            end
        end
        bus0.wr_en = 1'b0;
        for (int k = 0; k < 64; k++) begin
            bus0.rd_en = 1'b1;
            cyc();
            exp_d = exp_q.pop_front();
            n_cmp++;
            if (bus0.buf_out !== exp_d) begin
                n_bad++; $display("FAIL wrap_drain[%0d]: got %h expected %h", k, bus0.buf_out, exp_d);
            end
        end
        bus0.rd_en = 1'b0;
        n_cmp++;
        if (bus0.buf_empty !== 1'b1 || bus0.fifo_counter !== 7'd0) begin
            n_bad++; $display("FAIL wrap_empty: got %b/%0d expected 1/0", bus0.buf_empty, bus0.fifo_counter);
        end
    endtask

    task automatic test_empty_rw();
        bus0.wr_en = 1'b1; bus0.rd_en = 1'b1; bus0.buf_in = 8'hA5;
        cyc();
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
        n_cmp++;
        if (bus0.underflow !== 1'b1) begin
            n_bad++; $display("FAIL erw_underflow: got %b expected 1", bus0.underflow);
        end
        n_cmp++;
        if (bus0.fifo_counter !== 7'd1 || bus0.buf_empty !== 1'b0) begin
            n_bad++; $display("FAIL erw_count: got %0d/%b expected 1/0", bus0.fifo_counter, bus0.buf_empty);
        end
        bus0.rd_en = 1'b1;
        cyc();
        bus0.rd_en = 1'b0;
        n_cmp++;
        if (bus0.buf_out !== 8'hA5 || bus0.fifo_counter !== 7'd0 || bus0.underflow !== 1'b0) begin
            n_bad++; $display("FAIL erw_read: got %h/%0d/%b expected a5/0/0",
                              bus0.buf_out, bus0.fifo_counter, bus0.underflow);
        end
    endtask

    task automatic test_fwft();
        bus1.wr_en = 1'b1; bus1.buf_in = 8'h11;
        cyc();
        n_cmp++;
        if (bus1.buf_out !== 8'h11 || bus1.fifo_counter !== 7'd1 || bus1.buf_empty !== 1'b0) begin
            n_bad++; $display("FAIL fwft_first: got %h/%0d/%b expected 11/1/0",
                              bus1.buf_out, bus1.fifo_counter, bus1.buf_empty);
        end
        bus1.buf_in = 8'h22;
        cyc();
        bus1.wr_en = 1'b0;
        n_cmp++;
        if (bus1.buf_out !== 8'h11 || bus1.fifo_counter !== 7'd2) begin
            n_bad++; $display("FAIL fwft_hold: got %h/%0d expected 11/2", bus1.buf_out, bus1.fifo_counter);
        end
        cyc();
        n_cmp++;
        if (bus1.buf_out !== 8'h11) begin
            n_bad++; $display("FAIL fwft_idle: got %h expected 11", bus1.buf_out);
        end
        bus1.rd_en = 1'b1;
        cyc();
        bus1.rd_en = 1'b0;
        n_cmp++;
        if (bus1.buf_out !== 8'h22 || bus1.fifo_counter !== 7'd1) begin
            n_bad++; $display("FAIL fwft_pop: got %h/%0d expected 22/1", bus1.buf_out, bus1.fifo_counter);
        end
        bus1.rd_en = 1'b1;
        cyc();
        bus1.rd_en = 1'b0;
        n_cmp++;
        if (bus1.buf_empty !== 1'b1 || bus1.fifo_counter !== 7'd0) begin
            n_bad++; $display("FAIL fwft_empty: got %b/%0d expected 1/0", bus1.buf_empty, bus1.fifo_counter);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 30; i++) begin
            bus0.wr_en = 1'b1; bus0.buf_in = DATA_W'(i);
            cyc();
        end
        n_cmp++;
        if (bus0.fifo_counter !== 7'd30) begin
            n_bad++; $display("FAIL mid_count: got %0d expected 30", bus0.fifo_counter);
        end
        bus0.rd_en = 1'b1; bus0.buf_in = 8'h1F;    // one write+read so buf_out is non-zero
        cyc();
        bus0.rd_en = 1'b0;
        n_cmp++;
        if (bus0.buf_out !== 8'h01 || bus0.fifo_counter !== 7'd30) begin
            n_bad++; $display("FAIL mid_rw: got %h/%0d expected 01/30", bus0.buf_out, bus0.fifo_counter);
        end
        #3;
        rst = 1'b1;                                // mid-cycle, writes still requested
        #1;
        stat = {bus0.buf_out, bus0.fifo_counter, bus0.buf_empty, bus0.buf_full,
                bus0.almost_empty, bus0.almost_full, bus0.overflow, bus0.underflow};
        n_cmp++;
        if (stat !== RESET_STAT) begin
            n_bad++; $display("FAIL mid_async_reset: got %h expected %h", stat, RESET_STAT);
        end
        cyc();
        n_cmp++;
        if (bus0.fifo_counter !== 7'd0 || bus0.buf_empty !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_held: got %0d/%b expected 0/1", bus0.fifo_counter, bus0.buf_empty);
        end
        @(negedge clk);
        rst = 1'b0;
        bus0.wr_en = 1'b0;
        exp_q.delete();
        cyc();
        bus0.wr_en = 1'b1; bus0.buf_in = 8'h33;
        cyc();
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b1;
        cyc();
        bus0.rd_en = 1'b0;
        n_cmp++;
        if (bus0.buf_out !== 8'h33 || bus0.fifo_counter !== 7'd0 || bus0.buf_empty !== 1'b1) begin
            n_bad++; $display("FAIL mid_resume: got %h/%0d/%b expected 33/0/1",
                              bus0.buf_out, bus0.fifo_counter, bus0.buf_empty);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_sync_param
